// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled SCK/CS/MOSI, one-byte TX holding register,
// received bytes presented as single-cycle strobes.
module spi_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       spi_sck,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sck_chain;
    logic [SYNC_STAGES-1:0] cs_chain;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   sck_d;
    logic                   cs_d;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_rise_c;
    logic sck_fall_c;
    logic cs_fall_c;
    logic cs_rise_c;

    logic start_c;
    logic abort_c;
    logic sample_c;
    logic load_c;
    logic shift_c;
    logic write_c;

    logic [CNT_W-1:0]  bitcnt;
    logic [BYTE_W-1:0] rx_sr;
    logic [BYTE_W-1:0] tx_sr;
    logic [BYTE_W-1:0] hold_data;
    logic              reload_pending;

    assign sck_s  = sck_chain[SYNC_STAGES-1];
    assign cs_s   = cs_chain[SYNC_STAGES-1];
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    assign sck_rise_c = sck_s & ~sck_d;
    assign sck_fall_c = ~sck_s & sck_d;
    assign cs_fall_c  = ~cs_s & cs_d;
    assign cs_rise_c  = cs_s & ~cs_d;

    assign write_c = tx_valid & tx_ready;
    assign busy    = ~cs_s;

    // Input synchronizers plus one-flop delay for edge detection; CS resets deasserted.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            sck_chain  <= '0;
            cs_chain   <= '1;
            mosi_chain <= '0;
            sck_d      <= 1'b0;
            cs_d       <= 1'b1;
        end else begin
            sck_chain  <= {sck_chain[SYNC_STAGES-2:0], spi_sck};
            cs_chain   <= {cs_chain[SYNC_STAGES-2:0], spi_cs};
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
            sck_d      <= sck_s;
            cs_d       <= cs_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: CS edges move between IDLE and ACTIVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall_c) state_d = ACTIVE;
            ACTIVE:  if (cs_rise_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM control decode: CS edges win over a coincident SCK edge.
    always_comb begin
        start_c  = 1'b0;
        abort_c  = 1'b0;
        sample_c = 1'b0;
        load_c   = 1'b0;
        shift_c  = 1'b0;
        case (state_q)
            IDLE: begin
                start_c = cs_fall_c;
                load_c  = cs_fall_c;
            end
            ACTIVE: begin
                if (cs_rise_c) begin
                    abort_c = 1'b1;
                end else if (!cs_fall_c) begin
                    sample_c = sck_rise_c;
                    load_c   = sck_fall_c & reload_pending;
                    shift_c  = sck_fall_c & ~reload_pending;
                end
            end
            default: begin
                abort_c = 1'b1;
            end
        endcase
    end

    // Datapath: holding register, shift registers, bit counter and strobes.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            spi_miso       <= 1'b0;
            spi_miso_oe    <= 1'b0;
            tx_ready       <= 1'b1;
            hold_data      <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            tx_underrun    <= 1'b0;
            bitcnt         <= '0;
            rx_sr          <= '0;
            tx_sr          <= '0;
            reload_pending <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            // A write never reaches a load in the same cycle; it simply fills the register.
            if (write_c) begin
                hold_data <= tx_data;
                tx_ready  <= 1'b0;
            end

            if (start_c) begin
                bitcnt <= '0;
                rx_sr  <= '0;
            end

            if (load_c) begin
                if (!tx_ready) begin
                    tx_sr    <= hold_data;
                    spi_miso <= hold_data[BYTE_W-1];
                    tx_ready <= 1'b1;
                end else begin
                    tx_sr       <= FILL_BYTE;
                    spi_miso    <= FILL_BYTE[BYTE_W-1];
                    tx_underrun <= 1'b1;
                end
                spi_miso_oe    <= 1'b1;
                reload_pending <= 1'b0;
            end

            if (shift_c) begin
                tx_sr    <= {tx_sr[BYTE_W-2:0], 1'b0};
                spi_miso <= tx_sr[BYTE_W-2];
            end

            if (sample_c) begin
                rx_sr  <= {rx_sr[BYTE_W-2:0], mosi_s};
                bitcnt <= bitcnt + CNT_W'(1);
                if (bitcnt == CNT_W'(7)) begin
                    rx_data        <= {rx_sr[BYTE_W-2:0], mosi_s};
                    rx_valid       <= 1'b1;
                    reload_pending <= 1'b1;
                end
            end

            // Partial bytes are dropped; the holding register is left untouched.
            if (abort_c) begin
                bitcnt         <= '0;
                rx_sr          <= '0;
                reload_pending <= 1'b0;
                spi_miso_oe    <= 1'b0;
                spi_miso       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: bench acts as a mode-0 SPI controller and
// compares against a byte-level model of the holding register and data streams.
module tb_spi_target;

    localparam int unsigned SYNC = 2;
    localparam int unsigned HALF = 4;
    localparam logic [7:0]  FILL = 8'hFF;

    logic       clk;
    logic       Rst;
    logic       spi_sck;
    logic       spi_cs;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    spi_target #(
        .SYNC_STAGES (SYNC),
        .FILL_BYTE   (FILL)
    ) dut (
        .clk         (clk),
        .Rst         (Rst),
        .spi_sck     (spi_sck),
        .spi_cs      (spi_cs),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one-entry holding register, underrun count, last received byte.
    bit         m_full;
    logic [7:0] m_hold;
    int         m_underruns;
    logic [7:0] m_last_rx;

    // Observed strobes.
    logic [7:0] rx_q[$];
    int         und_seen;

    // Per-transfer stimulus.
    logic [7:0] mosi_arr [256];
    bit         wr_en    [256];
    logic [7:0] wr_val   [256];

    // Monitor the receive and underrun strobes.
    always @(negedge clk) begin
        if (!Rst) begin
            if (rx_valid) rx_q.push_back(rx_data);
            if (tx_underrun) und_seen++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic m_load(output logic [7:0] b);
        if (m_full) begin
            b      = m_hold;
            m_full = 1'b0;
        end else begin
            b = FILL;
            m_underruns++;
        end
    endtask

    task automatic m_write(input logic [7:0] v);
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = v;
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < 256; k++) begin
            mosi_arr[k] = 8'h00;
            wr_en[k]    = 1'b0;
            wr_val[k]   = 8'h00;
        end
    endtask

    // One-cycle write attempt; tx_ready must reflect the model before the attempt.
    task automatic do_write(input logic [7:0] v);
        n_checks++;
        if (tx_ready !== !m_full) begin
            n_fail++;
            $display("FAIL tx_ready_before_write: got %b want %b", tx_ready, !m_full);
        end
        tx_data  = v;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        m_write(v);
    endtask

    // Run one CS window of n bytes; stop_after>0 releases CS after that many SCK cycles.
    task automatic xfer(input int n, input int stop_after, input bit sc_wr, input logic [7:0] sc_val);
        logic [7:0] exp_b;
        logic [7:0] got_b;
        bit         early;
        int         nbits;
        logic [7:0] exp_rx[$];
        early = (stop_after > 0);
        nbits = 0;
        rx_q.delete();
        spi_cs = 1'b0;
        if (sc_wr) begin
            repeat (SYNC) @(negedge clk);
            n_checks++;
            if (tx_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL same_cycle_ready: got %b want 1", tx_ready);
            end
            tx_data  = sc_val;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            m_load(exp_b);
            m_write(sc_val);
        end else begin
            m_load(exp_b);
        end
        for (int b = 0; b < n; b++) begin
            if (b > 0) m_load(exp_b);
            got_b = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                spi_mosi = mosi_arr[b][i];
                repeat (HALF) @(negedge clk);
                got_b[i] = spi_miso;
                if (i == 7) begin
                    n_checks++;
                    if (und_seen !== m_underruns) begin
                        n_fail++;
                        $display("FAIL underrun_count byte %0d: got %0d want %0d", b, und_seen, m_underruns);
                    end
                    if (b == 0) begin
                        n_checks++;
                        if (spi_miso_oe !== 1'b1 || busy !== 1'b1) begin
                            n_fail++;
                            $display("FAIL active_oe_busy: got oe=%b busy=%b want 1/1", spi_miso_oe, busy);
                        end
                    end
                end
                spi_sck = 1'b1;
                nbits++;
                if (i == 4 && wr_en[b]) begin
                    do_write(wr_val[b]);
                    repeat (HALF - 1) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
                spi_sck = 1'b0;
                // Raising CS with the final SCK fall drops that fall, so no trailing reload.
                if ((b == n - 1 && i == 0) || (early && nbits == stop_after)) spi_cs = 1'b1;
                if (early && nbits == stop_after) break;
            end
            if (early) break;
            exp_rx.push_back(mosi_arr[b]);
            m_last_rx = mosi_arr[b];
            n_checks++;
            if (got_b !== exp_b) begin
                n_fail++;
                $display("FAIL miso_byte %0d: got %h want %h", b, got_b, exp_b);
            end
        end
        repeat (HALF + SYNC + 2) @(negedge clk);
        n_checks++;
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_cs: got oe=%b miso=%b busy=%b want 0/0/0", spi_miso_oe, spi_miso, busy);
        end
        n_checks++;
        if (rx_q.size() !== exp_rx.size()) begin
            n_fail++;
            $display("FAIL rx_count: got %0d want %0d", rx_q.size(), exp_rx.size());
        end else begin
            for (int k = 0; k < exp_rx.size(); k++) begin
                n_checks++;
                if (rx_q[k] !== exp_rx[k]) begin
                    n_fail++;
                    $display("FAIL rx_byte %0d: got %h want %h", k, rx_q[k], exp_rx[k]);
                end
            end
        end
        n_checks++;
        if (rx_data !== m_last_rx) begin
            n_fail++;
            $display("FAIL rx_data_hold: got %h want %h", rx_data, m_last_rx);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(negedge clk);
        Rst = 1'b0;
        m_full = 1'b0;
        m_hold = 8'h00;
        m_last_rx = 8'h00;
        repeat (SYNC + 2) @(negedge clk);
        n_checks++;
        if ({spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got miso=%b oe=%b rdy=%b rx=%h rv=%b und=%b busy=%b want 0 0 1 00 0 0 0",
                     spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy);
        end
    endtask

    task automatic test_single();
        clear_stim();
        do_write(8'hA5);
        n_checks++;
        if (tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_ready_after_write: got %b want 0", tx_ready);
        end
        mosi_arr[0] = 8'h3C;
        xfer(1, 0, 1'b0, 8'h00);
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_ready_after_load: got %b want 1", tx_ready);
        end
    endtask

    task automatic test_back_to_back();
        int und0;
        clear_stim();
        do_write(8'h11);
        mosi_arr[0] = 8'h01;
        mosi_arr[1] = 8'h02;
        mosi_arr[2] = 8'h03;
        wr_en[0]    = 1'b1;
        wr_val[0]   = 8'h22;
        und0 = und_seen;
        xfer(3, 0, 1'b0, 8'h00);
        n_checks++;
        if (und_seen - und0 !== 1) begin
            n_fail++;
            $display("FAIL b2b_underrun_pulses: got %0d want 1", und_seen - und0);
        end
    endtask

    task automatic test_early_cs();
        clear_stim();
        mosi_arr[0] = 8'($urandom);
        xfer(1, 5, 1'b0, 8'h00);
        clear_stim();
        mosi_arr[0] = 8'hC3;
        xfer(1, 0, 1'b0, 8'h00);
        n_checks++;
        if (rx_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL early_then_full: got %h want c3", rx_data);
        end
    endtask

    task automatic test_hold_rules();
        clear_stim();
        do_write(8'h55);
        do_write(8'h66);
        mosi_arr[0] = 8'($urandom);
        xfer(1, 0, 1'b0, 8'h00);
        clear_stim();
        mosi_arr[0] = 8'($urandom);
        mosi_arr[1] = 8'($urandom);
        xfer(2, 0, 1'b1, 8'h77);
    endtask

    task automatic test_reset_mid();
        logic [7:0] dummy;
        do_write(8'h9A);
        rx_q.delete();
        spi_cs = 1'b0;
        m_load(dummy);
        for (int i = 0; i < 3; i++) begin
            spi_mosi = 1'($urandom);
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
        do_write(8'h5B);
        spi_mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sck = 1'b1;
        repeat (2) @(negedge clk);
        Rst = 1'b1;
        m_full = 1'b0;
        m_last_rx = 8'h00;
        #1;
        n_checks++;
        if ({spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_byte: got miso=%b oe=%b rdy=%b rx=%h rv=%b und=%b busy=%b want 0 0 1 00 0 0 0",
                     spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy);
        end
        spi_sck  = 1'b0;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        Rst = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || spi_miso_oe !== 1'b0 || tx_ready !== 1'b1 || rx_q.size() !== 0) begin
            n_fail++;
            $display("FAIL after_reset_release: got busy=%b oe=%b rdy=%b rx=%0d want 0 0 1 0",
                     busy, spi_miso_oe, tx_ready, rx_q.size());
        end
    endtask

    task automatic test_idle_sck();
        rx_q.delete();
        for (int i = 0; i < 10; i++) begin
            spi_mosi = 1'($urandom);
            spi_sck  = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck  = 1'b0;
            repeat (HALF) @(negedge clk);
            n_checks++;
            if (spi_miso_oe !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_sck_oe: got oe=%b busy=%b want 0/0", spi_miso_oe, busy);
            end
        end
        n_checks++;
        if (rx_q.size() !== 0) begin
            n_fail++;
            $display("FAIL idle_sck_rx: got %0d strobes want 0", rx_q.size());
        end
    endtask

    task automatic test_rate_random();
        for (int w = 0; w < 8; w++) begin
            clear_stim();
            for (int k = 0; k < 32; k++) begin
                mosi_arr[k] = 8'($urandom);
                wr_en[k]    = 1'($urandom);
                wr_val[k]   = 8'($urandom);
            end
            if (m_full == 1'b0 && $urandom_range(0, 1) == 1) do_write(8'($urandom));
            xfer(32, 0, 1'b0, 8'h00);
        end
    endtask

    initial begin
        Rst         = 1'b1;
        spi_sck     = 1'b0;
        spi_cs      = 1'b1;
        spi_mosi    = 1'b0;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        m_full      = 1'b0;
        m_hold      = 8'h00;
        m_underruns = 0;
        m_last_rx   = 8'h00;
        und_seen    = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_early_cs();
        test_hold_rules();
        test_reset_mid();
        test_idle_sck();
        test_rate_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
